// File: rtl/reset_seq_timer.sv
// Reset sequencer: holds N_DOM reset domains, releases them staggered, then times a run window.
// Define RESET_SEQ_TIMER_REPULSE_EN to let rst_req restart the sequence from RELEASE or RUN.
module reset_seq_timer #(
    parameter int N_DOM       = 2,
    parameter int HOLD_CYC    = 4,
    parameter int STAGGER_CYC = 2,
    parameter int RUN_CYC     = 1400,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rst_req,
    output logic [N_DOM-1:0] dom_rst,
    output logic             run,
    output logic             done,
    output logic [CNT_W-1:0] cyc_cnt
);

    // Cycles from RELEASE entry until the last domain lets go.
    localparam int REL_SPAN = (N_DOM - 1) * STAGGER_CYC;
    localparam int HOLD_W   = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int REL_W    = (REL_SPAN > 1) ? $clog2(REL_SPAN) : 1;

    generate
        if (N_DOM < 1 || HOLD_CYC < 1 || RUN_CYC < 1 ||
            longint'(RUN_CYC) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_params
            $error("reset_seq_timer: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_HOLD,
        S_RELEASE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
    logic [REL_W-1:0]   rel_cnt, rel_nxt;
    logic [N_DOM-1:0]   dom_nxt;
    logic               run_nxt, done_nxt;
    logic [CNT_W-1:0]   cyc_nxt;
    logic               repulse;
    int                 rel_elapsed;

`ifdef RESET_SEQ_TIMER_REPULSE_EN
    assign repulse = rst_req && (state == S_RELEASE || state == S_RUN);
`else
    logic unused_rst_req;
    assign unused_rst_req = rst_req;
    assign repulse        = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned, which would infer a latch.
        state_nxt   = state;
        hold_nxt    = hold_cnt;
        rel_nxt     = rel_cnt;
        dom_nxt     = dom_rst;
        run_nxt     = run;
        done_nxt    = done;
        cyc_nxt     = cyc_cnt;
        rel_elapsed = int'(rel_cnt) + 1;

        case (state)
            S_HOLD: begin
                if (hold_cnt == HOLD_W'(HOLD_CYC - 1)) begin
                    hold_nxt = '0;
                    rel_nxt  = '0;
                    for (int i = 0; i < N_DOM; i++) begin
                        if (i * STAGGER_CYC == 0) dom_nxt[i] = 1'b0;
                    end
                    // With no stagger span the last domain drops on the RELEASE entry edge itself.
                    if (REL_SPAN == 0) begin
                        state_nxt = S_RUN;
                        run_nxt   = 1'b1;
                        cyc_nxt   = '0;
                    end else begin
                        state_nxt = S_RELEASE;
                    end
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end

            S_RELEASE: begin
                for (int i = 0; i < N_DOM; i++) begin
                    if (i * STAGGER_CYC <= rel_elapsed) dom_nxt[i] = 1'b0;
                end
                if (rel_elapsed == REL_SPAN) begin
                    state_nxt = S_RUN;
                    run_nxt   = 1'b1;
                    cyc_nxt   = '0;
                    rel_nxt   = '0;
                end else begin
                    rel_nxt = rel_cnt + REL_W'(1);
                end
            end

            S_RUN: begin
                if (cyc_cnt == CNT_W'(RUN_CYC - 1)) begin
                    state_nxt = S_DONE;
                    run_nxt   = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    cyc_nxt = cyc_cnt + CNT_W'(1);
                end
            end

            S_DONE: begin
                // Sticky until reset.
            end

            default: state_nxt = S_HOLD;
        endcase

        if (repulse) begin
            state_nxt = S_HOLD;
            hold_nxt  = '0;
            rel_nxt   = '0;
            dom_nxt   = '1;
            run_nxt   = 1'b0;
            cyc_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state    <= S_HOLD;
            hold_cnt <= '0;
            rel_cnt  <= '0;
            dom_rst  <= '1;
            run      <= 1'b0;
            done     <= 1'b0;
            cyc_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            rel_cnt  <= rel_nxt;
            dom_rst  <= dom_nxt;
            run      <= run_nxt;
            done     <= done_nxt;
            cyc_cnt  <= cyc_nxt;
        end
    end

endmodule

// File: tb/tb_reset_seq_timer.sv
// Directed bench for reset_seq_timer: three parameter sets, checked edge by edge against a timeline.
// Expectations for rst_req follow whether RESET_SEQ_TIMER_REPULSE_EN is defined.
`timescale 1ns/1ps
module tb_reset_seq_timer;

    logic clk = 1'b0;
    always #2.5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: default parameters.
    logic        reset_a = 1'b0, rst_req_a = 1'b0;
    logic [1:0]  dom_a;
    logic        run_a, done_a;
    logic [15:0] cyc_a;

    // Instance B: four domains released together after one hold cycle.
    logic        reset_b = 1'b0, rst_req_b = 1'b0;
    logic [3:0]  dom_b;
    logic        run_b, done_b;
    logic [7:0]  cyc_b;

    // Instance C: one-cycle run window on a one-bit counter.
    logic        reset_c = 1'b0, rst_req_c = 1'b0;
    logic [1:0]  dom_c;
    logic        run_c, done_c;
    logic [0:0]  cyc_c;

    reset_seq_timer dut_a (
        .clk(clk), .reset(reset_a), .rst_req(rst_req_a),
        .dom_rst(dom_a), .run(run_a), .done(done_a), .cyc_cnt(cyc_a)
    );

    reset_seq_timer #(
        .N_DOM(4), .HOLD_CYC(1), .STAGGER_CYC(0), .RUN_CYC(5), .CNT_W(8)
    ) dut_b (
        .clk(clk), .reset(reset_b), .rst_req(rst_req_b),
        .dom_rst(dom_b), .run(run_b), .done(done_b), .cyc_cnt(cyc_b)
    );

    reset_seq_timer #(
        .RUN_CYC(1), .CNT_W(1)
    ) dut_c (
        .clk(clk), .reset(reset_c), .rst_req(rst_req_c),
        .dom_rst(dom_c), .run(run_c), .done(done_c), .cyc_cnt(cyc_c)
    );

    typedef struct packed {
        logic [3:0]  dom;
        logic        run;
        logic        done;
        logic [15:0] cyc;
    } obs_t;

    // Expected outputs k edges after the last reset-low edge (k=0 is the reset state).
    function automatic obs_t expect_at(input int k, input int n, input int h, input int s, input int r);
        obs_t e;
        int   rs;
        int   de;
        rs    = h + (n - 1) * s;
        de    = rs + r;
        e.dom = '0;
        for (int i = 0; i < n; i++) e.dom[i] = (k < h + i * s);
        e.run  = (k >= rs) && (k < de);
        e.done = (k >= de);
        if (k < rs)              e.cyc = 16'd0;
        else if (k - rs > r - 1) e.cyc = 16'(r - 1);
        else                     e.cyc = 16'(k - rs);
        return e;
    endfunction

    function automatic obs_t get_a();
        obs_t o;
        o.dom = 4'(dom_a); o.run = run_a; o.done = done_a; o.cyc = 16'(cyc_a);
        return o;
    endfunction

    function automatic obs_t get_b();
        obs_t o;
        o.dom = dom_b; o.run = run_b; o.done = done_b; o.cyc = 16'(cyc_b);
        return o;
    endfunction

    function automatic obs_t get_c();
        obs_t o;
        o.dom = 4'(dom_c); o.run = run_c; o.done = done_c; o.cyc = 16'(cyc_c);
        return o;
    endfunction

    // Inputs change just after a falling edge; outputs are read on falling edges.
    task automatic apply_reset_a(input int cycles);
        reset_a = 1'b0;
        repeat (cycles) @(negedge clk);
        reset_a = 1'b1;
    endtask

    task automatic apply_reset_b(input int cycles);
        reset_b = 1'b0;
        repeat (cycles) @(negedge clk);
        reset_b = 1'b1;
    endtask

    task automatic apply_reset_c(input int cycles);
        reset_c = 1'b0;
        repeat (cycles) @(negedge clk);
        reset_c = 1'b1;
    endtask

    task automatic test_default_seq();
        obs_t e;
        apply_reset_a(2);
        e = expect_at(0, 2, 4, 2, 1400);
        checks++;
        if (get_a() !== e) begin
            failures++;
            $display("FAIL default_reset got=%h exp=%h", get_a(), e);
        end
        for (int k = 1; k <= 1410; k++) begin
            @(negedge clk);
            e = expect_at(k, 2, 4, 2, 1400);
            checks++;
            if (get_a() !== e) begin
                failures++;
                $display("FAIL default_seq k=%0d got=%h exp=%h", k, get_a(), e);
            end
        end
    endtask

    task automatic test_rst_req();
        obs_t e;
        apply_reset_a(2);
        for (int k = 1; k <= 106; k++) begin
            @(negedge clk);
            e = expect_at(k, 2, 4, 2, 1400);
            checks++;
            if (get_a() !== e) begin
                failures++;
                $display("FAIL rst_req_pre k=%0d got=%h exp=%h", k, get_a(), e);
            end
        end
        // cyc_cnt is 100 here; request is sampled on the next edge only.
        rst_req_a = 1'b1;
        @(negedge clk);
        rst_req_a = 1'b0;
`ifdef RESET_SEQ_TIMER_REPULSE_EN
        e = expect_at(0, 2, 4, 2, 1400);
        checks++;
        if (get_a() !== e) begin
            failures++;
            $display("FAIL rst_req_repulse got=%h exp=%h", get_a(), e);
        end
        for (int k = 1; k <= 1410; k++) begin
            @(negedge clk);
            e = expect_at(k, 2, 4, 2, 1400);
            checks++;
            if (get_a() !== e) begin
                failures++;
                $display("FAIL rst_req_restart k=%0d got=%h exp=%h", k, get_a(), e);
            end
        end
`else
        e = expect_at(107, 2, 4, 2, 1400);
        checks++;
        if (get_a() !== e) begin
            failures++;
            $display("FAIL rst_req_ignored got=%h exp=%h", get_a(), e);
        end
        for (int k = 108; k <= 1410; k++) begin
            @(negedge clk);
            e = expect_at(k, 2, 4, 2, 1400);
            checks++;
            if (get_a() !== e) begin
                failures++;
                $display("FAIL rst_req_continue k=%0d got=%h exp=%h", k, get_a(), e);
            end
        end
`endif
    endtask

    // Entered with instance A sitting in DONE.
    task automatic test_reset_in_done();
        obs_t e;
        checks++;
        if (done_a !== 1'b1) begin
            failures++;
            $display("FAIL done_precondition got=%b exp=1", done_a);
        end
        apply_reset_a(1);
        e = expect_at(0, 2, 4, 2, 1400);
        checks++;
        if (get_a() !== e) begin
            failures++;
            $display("FAIL reset_in_done got=%h exp=%h", get_a(), e);
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            e = expect_at(k, 2, 4, 2, 1400);
            checks++;
            if (get_a() !== e) begin
                failures++;
                $display("FAIL done_restart k=%0d got=%h exp=%h", k, get_a(), e);
            end
        end
    endtask

    // Entered with instance A two cycles into RUN; resets mid-RUN, then mid-RELEASE with rst_req high.
    task automatic test_reset_midway();
        obs_t e;
        apply_reset_a(1);
        e = expect_at(0, 2, 4, 2, 1400);
        checks++;
        if (get_a() !== e) begin
            failures++;
            $display("FAIL reset_mid_run got=%h exp=%h", get_a(), e);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            e = expect_at(k, 2, 4, 2, 1400);
            checks++;
            if (get_a() !== e) begin
                failures++;
                $display("FAIL mid_run_restart k=%0d got=%h exp=%h", k, get_a(), e);
            end
        end
        rst_req_a = 1'b1;
        apply_reset_a(1);
        rst_req_a = 1'b0;
        e = expect_at(0, 2, 4, 2, 1400);
        checks++;
        if (get_a() !== e) begin
            failures++;
            $display("FAIL reset_mid_release got=%h exp=%h", get_a(), e);
        end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            e = expect_at(k, 2, 4, 2, 1400);
            checks++;
            if (get_a() !== e) begin
                failures++;
                $display("FAIL mid_release_restart k=%0d got=%h exp=%h", k, get_a(), e);
            end
        end
    endtask

    task automatic test_same_edge();
        obs_t e;
        apply_reset_b(2);
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) @(negedge clk);
            e = expect_at(k, 4, 1, 0, 5);
            checks++;
            if (get_b() !== e) begin
                failures++;
                $display("FAIL same_edge k=%0d got=%h exp=%h", k, get_b(), e);
            end
        end
    endtask

    task automatic test_run_cyc_one();
        obs_t e;
        apply_reset_c(2);
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) @(negedge clk);
            e = expect_at(k, 2, 4, 2, 1);
            checks++;
            if (get_c() !== e) begin
                failures++;
                $display("FAIL run_cyc_one k=%0d got=%h exp=%h", k, get_c(), e);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_default_seq();
        test_rst_req();
        test_reset_in_done();
        test_reset_midway();
        test_same_edge();
        test_run_cyc_one();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
